// File: rtl/alu_muldiv_seq.sv
// Sequential ALU with an iterative multiply/divide unit.
// Single-cycle ops finish one cycle after accept. MUL/DIV ops run a
// BITWIDTH-step shift-add or restoring-divide loop on operand magnitudes
// and apply the sign on the last step.
module alu_muldiv_seq #(
  parameter int BITWIDTH = 32,
  parameter int CNT_W    = $clog2(BITWIDTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] operand_A,
  input  logic [BITWIDTH-1:0] operand_B,
  input  logic [BITWIDTH-1:0] immediate,
  input  logic                ALUSrc,
  input  logic [4:0]          ALUOp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] ALU_Result,
  output logic                zero,
  output logic                less_than,
  output logic                less_than_unsigned,
  output logic                busy
);

  localparam int SH_W = $clog2(BITWIDTH);
  localparam logic [BITWIDTH-1:0] MIN_VAL = {1'b1, {(BITWIDTH-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SLL    = 5'b00111;
  localparam logic [4:0] OP_SRA    = 5'b01001;
  localparam logic [4:0] OP_SLTU   = 5'b01010;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [BITWIDTH-1:0] r_a;
  logic [BITWIDTH-1:0] r_b;
  logic [4:0]          r_op;
  logic [BITWIDTH-1:0] r_acc;
  logic [BITWIDTH-1:0] r_shf;
  logic [BITWIDTH-1:0] r_mag;
  logic                r_sa;
  logic                r_sb;
  logic [CNT_W-1:0]    r_cnt;
  logic [BITWIDTH-1:0] r_result;
  logic                r_zero;
  logic                r_lt;
  logic                r_ltu;

  logic [BITWIDTH-1:0]   w_b_in;
  logic [SH_W-1:0]       w_shamt;
  logic                  w_accept;
  logic                  w_is_iter;
  logic                  w_eq_in;
  logic                  w_lt_in;
  logic                  w_ltu_in;
  logic [BITWIDTH-1:0]   w_single_res;
  logic                  w_single_ok;
  logic                  w_a_signed_op;
  logic                  w_b_signed_op;
  logic                  w_sa_in;
  logic                  w_sb_in;
  logic [BITWIDTH-1:0]   w_mag_a_in;
  logic [BITWIDTH-1:0]   w_mag_b_in;
  logic [BITWIDTH:0]     w_sum;
  logic [BITWIDTH:0]     w_trial;
  logic [BITWIDTH-1:0]   w_acc_nx;
  logic [BITWIDTH-1:0]   w_shf_nx;
  logic [2*BITWIDTH-1:0] w_prod;
  logic [2*BITWIDTH-1:0] w_prod_fix;
  logic [BITWIDTH-1:0]   w_quo_fix;
  logic [BITWIDTH-1:0]   w_rem_fix;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic                  w_last;
  logic [BITWIDTH-1:0]   w_iter_res;

  assign w_b_in    = ALUSrc ? immediate : operand_B;
  assign w_shamt   = w_b_in[SH_W-1:0];
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_is_iter = (ALUOp[4:3] == 2'b10);
  assign w_eq_in   = (operand_A == w_b_in);
  assign w_lt_in   = ($signed(operand_A) < $signed(w_b_in));
  assign w_ltu_in  = (operand_A < w_b_in);

  assign w_a_signed_op = (ALUOp == OP_MULH) || (ALUOp == OP_MULHSU) ||
                         (ALUOp == OP_DIV)  || (ALUOp == OP_REM);
  assign w_b_signed_op = (ALUOp == OP_MULH) || (ALUOp == OP_DIV) || (ALUOp == OP_REM);
  assign w_sa_in       = w_a_signed_op && operand_A[BITWIDTH-1];
  assign w_sb_in       = w_b_signed_op && w_b_in[BITWIDTH-1];
  assign w_mag_a_in    = w_sa_in ? -operand_A : operand_A;
  assign w_mag_b_in    = w_sb_in ? -w_b_in : w_b_in;

  assign w_sum   = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_mag} : {(BITWIDTH+1){1'b0}});
  assign w_trial = {r_acc, r_shf[BITWIDTH-1]} - {1'b0, r_mag};

  assign w_last     = (r_cnt == CNT_W'(BITWIDTH - 1));
  assign w_prod     = {w_acc_nx, w_shf_nx};
  assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_sa ^ r_sb) ? -w_shf_nx : w_shf_nx;
  assign w_rem_fix  = r_sa ? -w_acc_nx : w_acc_nx;
  assign w_div_zero = (r_b == '0);
  assign w_div_ovf  = !r_op[0] && (r_a == MIN_VAL) && (r_b == {BITWIDTH{1'b1}});

  assign ALU_Result         = r_result;
  assign zero               = r_zero;
  assign less_than          = r_lt;
  assign less_than_unsigned = r_ltu;

  // Single-cycle result straight from the request inputs; unknown codes flagged not-ok
  always_comb begin
    w_single_res = '0;
    w_single_ok  = 1'b1;
    case (ALUOp)
      OP_ADD:  w_single_res = operand_A + w_b_in;
      OP_SUB:  w_single_res = operand_A - w_b_in;
      OP_AND:  w_single_res = operand_A & w_b_in;
      OP_OR:   w_single_res = operand_A | w_b_in;
      OP_XOR:  w_single_res = operand_A ^ w_b_in;
      OP_SLT:  w_single_res = {{(BITWIDTH-1){1'b0}}, w_lt_in};
      OP_SLTU: w_single_res = {{(BITWIDTH-1){1'b0}}, w_ltu_in};
      OP_SRL:  w_single_res = operand_A >> w_shamt;
      OP_SLL:  w_single_res = operand_A << w_shamt;
      OP_SRA:  w_single_res = $signed(operand_A) >>> w_shamt;
      default: w_single_ok  = 1'b0;
    endcase
  end

  // One loop step: shift-add for multiply (op[2]=0), restoring divide for divide (op[2]=1)
  always_comb begin
    w_acc_nx = r_acc;
    w_shf_nx = r_shf;
    if (r_op[2]) begin
      if (w_trial[BITWIDTH]) begin
        w_acc_nx = {r_acc[BITWIDTH-2:0], r_shf[BITWIDTH-1]};
      end else begin
        w_acc_nx = w_trial[BITWIDTH-1:0];
      end
      w_shf_nx = {r_shf[BITWIDTH-2:0], !w_trial[BITWIDTH]};
    end else begin
      w_acc_nx = w_sum[BITWIDTH:1];
      w_shf_nx = {w_sum[0], r_shf[BITWIDTH-1:1]};
    end
  end

  // Final iterative result from the last step, with sign fix and divide corner cases
  always_comb begin
    w_iter_res = '0;
    case (r_op)
      OP_MUL: w_iter_res = w_prod_fix[BITWIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_iter_res = w_prod_fix[2*BITWIDTH-1:BITWIDTH];
      OP_DIV, OP_DIVU: begin
        if (w_div_zero)     w_iter_res = {BITWIDTH{1'b1}};
        else if (w_div_ovf) w_iter_res = r_a;
        else                w_iter_res = w_quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (w_div_zero)     w_iter_res = r_a;
        else if (w_div_ovf) w_iter_res = '0;
        else                w_iter_res = w_rem_fix;
      end
      default: w_iter_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = w_is_iter ? CALC : DONE;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Operand capture, loop registers, and result/flag registers (written only on entry to DONE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_shf    <= '0;
      r_mag    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
      r_ltu    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= operand_A;
            r_b   <= w_b_in;
            r_op  <= ALUOp;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_is_iter) begin
              r_sa <= w_sa_in;
              r_sb <= w_sb_in;
              if (ALUOp[2]) begin
                r_shf <= w_mag_a_in;
                r_mag <= w_mag_b_in;
              end else begin
                r_shf <= w_mag_b_in;
                r_mag <= w_mag_a_in;
              end
            end else begin
              r_result <= w_single_ok ? w_single_res : '0;
              r_zero   <= w_single_ok && w_eq_in;
              r_lt     <= w_single_ok && w_lt_in;
              r_ltu    <= w_single_ok && w_ltu_in;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_nx;
          r_shf <= w_shf_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_iter_res;
            r_zero   <= (r_a == r_b);
            r_lt     <= ($signed(r_a) < $signed(r_b));
            r_ltu    <= (r_a < r_b);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
